// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo
//   Buffers {left,right} sample pairs from the receiver/ASRC stage in a small
//   FIFO and regenerates an I2S master bus (BCK/WS/DATA) from AMCLK_i.
//   A PRIME/RUN state machine holds off popping until the FIFO is half full.
//   A frame that starts while RUN finds the FIFO empty is muted and drops
//   the machine back to PRIME.
//
// Ports
//   AMCLK_i         in   audio master clock, all logic on posedge
//   reset_n         in   async active-low reset
//   APDATA_LEFT_i   in   signed left sample
//   APDATA_RIGHT_i  in   signed right sample
//   APDATA_VALID_i  in   1-cycle strobe, push {L,R}
//   clear_flags_i   in   sync clear of sticky flags (a same-cycle event wins)
//   I2S_BCK_o       out  bit clock, AMCLK_i/BCK_DIV, 50% duty
//   I2S_WS_o        out  0 = left slot, 1 = right slot
//   I2S_DATA_o      out  serial data, MSB first, one BCK after the WS edge
//   fifo_level_o    out  FIFO occupancy 0..FIFO_DEPTH
//   underrun_o      out  sticky: a RUN frame started with the FIFO empty
//   overflow_o      out  sticky: a push was dropped because the FIFO was full
module i2s_tx_fifo #(
  parameter int I2S_DATA_BITS = 16,
  parameter int SLOT_BITS     = 32,
  parameter int BCK_DIV       = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          AMCLK_i,
  input  logic                          reset_n,
  input  logic [I2S_DATA_BITS-1:0]      APDATA_LEFT_i,
  input  logic [I2S_DATA_BITS-1:0]      APDATA_RIGHT_i,
  input  logic                          APDATA_VALID_i,
  input  logic                          clear_flags_i,
  output logic                          I2S_BCK_o,
  output logic                          I2S_WS_o,
  output logic                          I2S_DATA_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          underrun_o,
  output logic                          overflow_o
);

  localparam int DW = I2S_DATA_BITS;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BCK_DIV);
  localparam int BW = $clog2(2 * SLOT_BITS);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                           state_q, state_d;
  logic [CW-1:0]                    bck_ctr_q, bck_ctr_d;
  logic [BW-1:0]                    bit_ctr_q, bit_ctr_d;
  logic                             bck_q, bck_d;
  logic                             ws_q, ws_d;
  logic                             data_q, data_d;
  logic [DW-1:0]                    tx_l_q, tx_l_d, tx_r_q, tx_r_d;
  logic [FIFO_DEPTH-1:0][2*DW-1:0]  mem_q, mem_d;
  logic [AW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                    level_q, level_d;
  logic                             underrun_q, underrun_d;
  logic                             overflow_q, overflow_d;

  logic          fall_tick, frame_load;
  logic          pop, push, full, underrun_evt, overflow_evt;
  logic          right_slot, ser_bit;
  logic [BW-1:0] slot_p;
  logic [DW-1:0] cur_word, prev_word;

  // Bit clock and frame position
  always_comb begin
    fall_tick  = (bck_ctr_q == CW'(BCK_DIV - 1));
    frame_load = fall_tick && (bit_ctr_q == BW'(2 * SLOT_BITS - 1));
    bck_ctr_d  = fall_tick ? '0 : bck_ctr_q + CW'(1);
    bck_d      = (bck_ctr_d >= CW'(BCK_DIV / 2));
    bit_ctr_d  = bit_ctr_q;
    if (fall_tick) bit_ctr_d = frame_load ? '0 : bit_ctr_q + BW'(1);
  end

  // Serializer: computed for the position being entered on this fall tick.
  // At p=0 the bit is the LSB of the word that just ended (tx_r_q is still
  // the old frame's word at frame load), which only matters when the slot
  // has no padding.
  always_comb begin
    right_slot = (bit_ctr_d >= BW'(SLOT_BITS));
    slot_p     = right_slot ? bit_ctr_d - BW'(SLOT_BITS) : bit_ctr_d;
    cur_word   = right_slot ? tx_r_q : tx_l_q;
    prev_word  = right_slot ? tx_l_q : tx_r_q;
    ser_bit    = 1'b0;
    if (slot_p == '0) begin
      ser_bit = (SLOT_BITS == DW) ? prev_word[0] : 1'b0;
    end else begin
      for (int i = 0; i < DW; i++)
        if (slot_p == BW'(DW - i)) ser_bit = cur_word[i];
    end
    ws_d   = fall_tick ? right_slot : ws_q;
    data_d = fall_tick ? ser_bit : data_q;
  end

  // PRIME/RUN: decisions are only made at frame load, so tx words never
  // change mid-frame.
  always_comb begin
    state_d      = state_q;
    tx_l_d       = tx_l_q;
    tx_r_d       = tx_r_q;
    pop          = 1'b0;
    underrun_evt = 1'b0;
    if (frame_load) begin
      case (state_q)
        PRIME: begin
          tx_l_d = '0;
          tx_r_d = '0;
          if (level_q >= LW'(FIFO_DEPTH / 2)) state_d = RUN;
        end
        RUN: begin
          if (level_q != '0) begin
            pop              = 1'b1;
            {tx_l_d, tx_r_d} = mem_q[rd_ptr_q];
          end else begin
            tx_l_d       = '0;
            tx_r_d       = '0;
            underrun_evt = 1'b1;
            state_d      = PRIME;
          end
        end
      endcase
    end
  end

  // FIFO and sticky flags. A push into a full FIFO is still accepted when a
  // pop happens in the same cycle (pop reads the old entry first).
  always_comb begin
    full         = (level_q == LW'(FIFO_DEPTH));
    push         = APDATA_VALID_i && (!full || pop);
    overflow_evt = APDATA_VALID_i && full && !pop;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = {APDATA_LEFT_i, APDATA_RIGHT_i};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
    underrun_d = underrun_evt || (underrun_q && !clear_flags_i);
    overflow_d = overflow_evt || (overflow_q && !clear_flags_i);
  end

  always_ff @(posedge AMCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= PRIME;
      bck_ctr_q  <= '0;
      bit_ctr_q  <= '0;
      bck_q      <= 1'b0;
      ws_q       <= 1'b0;
      data_q     <= 1'b0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bck_ctr_q  <= bck_ctr_d;
      bit_ctr_q  <= bit_ctr_d;
      bck_q      <= bck_d;
      ws_q       <= ws_d;
      data_q     <= data_d;
      tx_l_q     <= tx_l_d;
      tx_r_q     <= tx_r_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
    end
  end

  assign I2S_BCK_o    = bck_q;
  assign I2S_WS_o     = ws_q;
  assign I2S_DATA_o   = data_q;
  assign fifo_level_o = level_q;
  assign underrun_o   = underrun_q;
  assign overflow_o   = overflow_q;

endmodule
